// File: rtl/pzcorebus_downsizer_response_packer.sv
`default_nettype none
// ============================================================================
// Module      : pzcorebus_downsizer_response_packer
// Description : Packs narrow read-response beats into wide response beats.
//               A small FIFO holds per-command info (starting lane, narrow
//               beat count). For each command the packer places narrow beats
//               into consecutive lanes of a wide beat, closing the wide beat
//               on the top lane or the final narrow beat, and presents it in
//               a one-entry output register.
// Ports       : i_clk, i_rst_n          clock, async active-low reset
//               i_cmd_*, o_cmd_ready    command-info push side
//               i_nresp_*, i_ndata,
//               i_nsinfo, o_nresp_accept narrow response input
//               o_wresp_*, o_wdata, o_wlane_valid, o_wsinfo,
//               i_wresp_accept          wide response output
//               o_error                 sticky beat-count/last disagreement
// Revision    : 1.0 - initial release
// ============================================================================
module pzcorebus_downsizer_response_packer #(
    parameter int NARROW_DATA_WIDTH = 64,
    parameter int CONVERSION_RATIO  = 2,
    parameter int BEATS_WIDTH       = 8,
    parameter int INFO_DEPTH        = 4,
    parameter int SINFO_WIDTH       = 8,
    localparam int LANE_WIDTH       = $clog2(CONVERSION_RATIO),
    localparam int WIDE_WIDTH       = NARROW_DATA_WIDTH * CONVERSION_RATIO
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [LANE_WIDTH-1:0]        i_cmd_offset,
    input  logic [BEATS_WIDTH-1:0]       i_cmd_beats,
    input  logic                         i_nresp_valid,
    output logic                         o_nresp_accept,
    input  logic [NARROW_DATA_WIDTH-1:0] i_ndata,
    input  logic                         i_nresp_last,
    input  logic [SINFO_WIDTH-1:0]       i_nsinfo,
    output logic                         o_wresp_valid,
    input  logic                         i_wresp_accept,
    output logic [WIDE_WIDTH-1:0]        o_wdata,
    output logic [CONVERSION_RATIO-1:0]  o_wlane_valid,
    output logic                         o_wresp_last,
    output logic [SINFO_WIDTH-1:0]       o_wsinfo,
    output logic                         o_error
);

    localparam int                    c_ADDR_WIDTH = $clog2(INFO_DEPTH);
    localparam int                    c_INFO_WIDTH = LANE_WIDTH + BEATS_WIDTH;
    localparam logic [c_ADDR_WIDTH:0] c_PTR_ONE    = (c_ADDR_WIDTH+1)'(1);
    localparam logic [BEATS_WIDTH:0]  c_REM_ONE    = (BEATS_WIDTH+1)'(1);
    localparam logic [LANE_WIDTH-1:0] c_LANE_ONE   = LANE_WIDTH'(1);
    localparam logic [LANE_WIDTH-1:0] c_LAST_LANE  = LANE_WIDTH'(CONVERSION_RATIO - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PACK = 1'b1;

    // ------------------------------------------------------------------
    // Command-info FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [c_INFO_WIDTH-1:0] r_info_mem [INFO_DEPTH];
    logic [c_ADDR_WIDTH:0]   r_wr_ptr;
    logic [c_ADDR_WIDTH:0]   r_rd_ptr;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [c_INFO_WIDTH-1:0] w_head;
    logic [LANE_WIDTH-1:0]   w_head_offset;
    logic [BEATS_WIDTH-1:0]  w_head_beats;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_WIDTH-1:0] == r_rd_ptr[c_ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[c_ADDR_WIDTH] != r_rd_ptr[c_ADDR_WIDTH]);
    assign w_push  = i_cmd_valid && !w_full;
    assign w_head  = r_info_mem[r_rd_ptr[c_ADDR_WIDTH-1:0]];
    assign w_head_offset = w_head[c_INFO_WIDTH-1:BEATS_WIDTH];
    assign w_head_beats  = w_head[BEATS_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_info_mem[r_wr_ptr[c_ADDR_WIDTH-1:0]] <= {i_cmd_offset, i_cmd_beats};
        end
    end

    // ------------------------------------------------------------------
    // Packer state
    // ------------------------------------------------------------------
    logic [0:0]                   r_state;
    logic [LANE_WIDTH-1:0]        r_lane;
    logic [BEATS_WIDTH:0]         r_remaining;
    logic [WIDE_WIDTH-1:0]        r_asm_data;
    logic [CONVERSION_RATIO-1:0]  r_asm_lanes;
    logic [SINFO_WIDTH-1:0]       r_asm_sinfo;
    logic                         r_out_valid;
    logic [WIDE_WIDTH-1:0]        r_out_data;
    logic [CONVERSION_RATIO-1:0]  r_out_lanes;
    logic                         r_out_last;
    logic [SINFO_WIDTH-1:0]       r_out_sinfo;
    logic                         r_error;

    logic                         w_last_beat;
    logic                         w_close;
    logic                         w_stall;
    logic                         w_nresp_accept;
    logic                         w_ntake;
    logic [WIDE_WIDTH-1:0]        w_merge_data;
    logic [CONVERSION_RATIO-1:0]  w_merge_lanes;
    logic [SINFO_WIDTH-1:0]       w_merge_sinfo;

    assign w_pop       = (r_state == c_ST_IDLE) && !w_empty;
    assign w_last_beat = (r_remaining == c_REM_ONE);
    // The close decision depends only on registered state, so the accept
    // below has no combinational path from i_nresp_valid.
    assign w_close     = (r_lane == c_LAST_LANE) || w_last_beat;
    // Only a closing beat needs room in the output register; a beat that
    // merely fills a lower lane can always be taken.
    assign w_stall        = w_close && r_out_valid && !i_wresp_accept;
    assign w_nresp_accept = (r_state == c_ST_PACK) && !w_stall;
    assign w_ntake        = i_nresp_valid && w_nresp_accept;

    for (genvar k = 0; k < CONVERSION_RATIO; k++) begin : g_lane
        assign w_merge_data[k*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH] =
            (r_lane == LANE_WIDTH'(k)) ? i_ndata
                                       : r_asm_data[k*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH];
        assign w_merge_lanes[k] = (r_lane == LANE_WIDTH'(k)) || r_asm_lanes[k];
    end

    // Side info comes from the first narrow beat placed in this wide beat.
    assign w_merge_sinfo = (r_asm_lanes == '0) ? i_nsinfo : r_asm_sinfo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= c_ST_IDLE;
            r_lane      <= '0;
            r_remaining <= '0;
            r_asm_data  <= '0;
            r_asm_lanes <= '0;
            r_asm_sinfo <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lanes <= '0;
            r_out_last  <= 1'b0;
            r_out_sinfo <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            // Output register: drained by the consumer, reloaded by a close.
            // Both on one edge keeps back-to-back wide beats at full rate.
            if (r_out_valid && i_wresp_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_ntake && w_close) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merge_data;
                r_out_lanes <= w_merge_lanes;
                r_out_last  <= w_last_beat;
                r_out_sinfo <= w_merge_sinfo;
            end

            if (w_ntake && (i_nresp_last != w_last_beat)) begin
                r_error <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_rd_ptr    <= r_rd_ptr + c_PTR_ONE;
                        r_lane      <= w_head_offset;
                        // A zero count means the full 2^BEATS_WIDTH beats.
                        r_remaining <= {(w_head_beats == '0), w_head_beats};
                        r_asm_data  <= '0;
                        r_asm_lanes <= '0;
                        r_asm_sinfo <= '0;
                        r_state     <= c_ST_PACK;
                    end
                end
                c_ST_PACK: begin
                    if (w_ntake) begin
                        r_lane      <= r_lane + c_LANE_ONE;
                        r_remaining <= r_remaining - c_REM_ONE;
                        if (w_close) begin
                            r_asm_data  <= '0;
                            r_asm_lanes <= '0;
                            r_asm_sinfo <= '0;
                        end else begin
                            r_asm_data  <= w_merge_data;
                            r_asm_lanes <= w_merge_lanes;
                            r_asm_sinfo <= w_merge_sinfo;
                        end
                        if (w_last_beat) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready    = !w_full;
    assign o_nresp_accept = w_nresp_accept;
    assign o_wresp_valid  = r_out_valid;
    assign o_wdata        = r_out_data;
    assign o_wlane_valid  = r_out_lanes;
    assign o_wresp_last   = r_out_last;
    assign o_wsinfo       = r_out_sinfo;
    assign o_error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pzcorebus_downsizer_response_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pzcorebus_downsizer_response_packer
// Description : Directed, table-driven bench for the response packer with
//               default parameters (64-bit narrow, ratio 2, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pzcorebus_downsizer_response_packer;

    localparam logic [63:0] c_DA = 64'hA1A1_A1A1_A1A1_A1A1;
    localparam logic [63:0] c_DB = 64'hB2B2_B2B2_B2B2_B2B2;
    localparam logic [63:0] c_DC = 64'hC3C3_C3C3_C3C3_C3C3;
    localparam logic [63:0] c_DD = 64'hD4D4_D4D4_D4D4_D4D4;
    localparam logic [63:0] c_Z  = 64'h0;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [0:0]   i_cmd_offset;
    logic [7:0]   i_cmd_beats;
    logic         i_nresp_valid;
    logic         o_nresp_accept;
    logic [63:0]  i_ndata;
    logic         i_nresp_last;
    logic [7:0]   i_nsinfo;
    logic         o_wresp_valid;
    logic         i_wresp_accept;
    logic [127:0] o_wdata;
    logic [1:0]   o_wlane_valid;
    logic         o_wresp_last;
    logic [7:0]   o_wsinfo;
    logic         o_error;

    pzcorebus_downsizer_response_packer u_dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_offset   (i_cmd_offset),
        .i_cmd_beats    (i_cmd_beats),
        .i_nresp_valid  (i_nresp_valid),
        .o_nresp_accept (o_nresp_accept),
        .i_ndata        (i_ndata),
        .i_nresp_last   (i_nresp_last),
        .i_nsinfo       (i_nsinfo),
        .o_wresp_valid  (o_wresp_valid),
        .i_wresp_accept (i_wresp_accept),
        .o_wdata        (o_wdata),
        .o_wlane_valid  (o_wlane_valid),
        .o_wresp_last   (o_wresp_last),
        .o_wsinfo       (o_wsinfo),
        .o_error        (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   lanes;
        logic         last;
        logic [7:0]   sinfo;
    } wbeat_t;

    typedef struct packed {
        logic              off;
        logic [7:0]        beats;
        logic [3:0][63:0]  d;
        logic [3:0]        nlast;
        int                nw;
        logic [3:0][127:0] wd;
        logic [3:0][1:0]   wl;
        logic [3:0]        wlast;
        logic [3:0][7:0]   ws;
    } vec_t;

    wbeat_t got_q[$];

    // Records every wide beat that will be handshaken at the next rising edge.
    initial begin
        wbeat_t w;
        forever begin
            @(negedge i_clk);
            #2;
            if (o_wresp_valid && i_wresp_accept) begin
                w.data  = o_wdata;
                w.lanes = o_wlane_valid;
                w.last  = o_wresp_last;
                w.sinfo = o_wsinfo;
                got_q.push_back(w);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no handshake expected one", name);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_cmd(input logic off, input logic [7:0] beats);
        int n;
        i_cmd_valid  = 1'b1;
        i_cmd_offset = off;
        i_cmd_beats  = beats;
        #1;
        n = 0;
        while (!o_cmd_ready && n < 40) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (n >= 40) timeout_fail("cmd_push");
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n;
        i_nresp_valid = 1'b1;
        i_ndata       = d;
        i_nsinfo      = s;
        i_nresp_last  = last;
        #1;
        n = 0;
        while (!o_nresp_accept && n < 40) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (n >= 40) timeout_fail("nresp_send");
        @(negedge i_clk);
        i_nresp_valid = 1'b0;
        i_nresp_last  = 1'b0;
    endtask

    vec_t tv[4];

    initial begin
        int n;
        // {lane1, lane0} ordering in every expected wide word.
        // Full aligned read of 4 beats
        tv[0].off = 1'b0; tv[0].beats = 8'd4; tv[0].d = {c_DD, c_DC, c_DB, c_DA}; tv[0].nlast = 4'b1000;
        tv[0].nw = 2; tv[0].wd = {128'h0, 128'h0, {c_DD, c_DC}, {c_DB, c_DA}};
        tv[0].wl = {2'b00, 2'b00, 2'b11, 2'b11}; tv[0].wlast = 4'b0010;
        tv[0].ws = {8'h00, 8'h00, 8'h12, 8'h10};
        // Offset 1, two beats: split across two wide beats
        tv[1].off = 1'b1; tv[1].beats = 8'd2; tv[1].d = {c_Z, c_Z, c_DB, c_DA}; tv[1].nlast = 4'b0010;
        tv[1].nw = 2; tv[1].wd = {128'h0, 128'h0, {c_Z, c_DB}, {c_DA, c_Z}};
        tv[1].wl = {2'b00, 2'b00, 2'b01, 2'b10}; tv[1].wlast = 4'b0010;
        tv[1].ws = {8'h00, 8'h00, 8'h11, 8'h10};
        // Single beat
        tv[2].off = 1'b0; tv[2].beats = 8'd1; tv[2].d = {c_Z, c_Z, c_Z, c_DA}; tv[2].nlast = 4'b0001;
        tv[2].nw = 1; tv[2].wd = {128'h0, 128'h0, 128'h0, {c_Z, c_DA}};
        tv[2].wl = {2'b00, 2'b00, 2'b00, 2'b01}; tv[2].wlast = 4'b0001;
        tv[2].ws = {8'h00, 8'h00, 8'h00, 8'h10};
        // Offset 1, three beats: partial first, full second
        tv[3].off = 1'b1; tv[3].beats = 8'd3; tv[3].d = {c_Z, c_DC, c_DB, c_DA}; tv[3].nlast = 4'b0100;
        tv[3].nw = 2; tv[3].wd = {128'h0, 128'h0, {c_DC, c_DB}, {c_DA, c_Z}};
        tv[3].wl = {2'b00, 2'b00, 2'b11, 2'b10}; tv[3].wlast = 4'b0010;
        tv[3].ws = {8'h00, 8'h00, 8'h11, 8'h10};

        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_offset = '0; i_cmd_beats = '0;
        i_nresp_valid = 1'b0; i_ndata = '0; i_nresp_last = 1'b0; i_nsinfo = '0;
        i_wresp_accept = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge i_clk);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_nresp_accept", o_nresp_accept, 0);
        check("rst_wresp_valid", o_wresp_valid, 0);
        check("rst_wresp_last", o_wresp_last, 0);
        check("rst_wlane_valid", o_wlane_valid, 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_wsinfo", o_wsinfo, 0);
        check("rst_error", o_error, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // No info queued: narrow beats must not be accepted.
        i_nresp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            #1;
            check("idle_no_accept", o_nresp_accept, 0);
        end
        i_nresp_valid = 1'b0;
        @(negedge i_clk);

        // ---------------- table-driven reads ----------------
        for (int i = 0; i < 4; i++) begin
            got_q.delete();
            push_cmd(tv[i].off, tv[i].beats);
            for (int b = 0; b < int'(tv[i].beats); b++)
                send_beat(tv[i].d[b], 8'(8'h10 + b), tv[i].nlast[b]);
            repeat (3) @(negedge i_clk);
            check($sformatf("v%0d_count", i), got_q.size(), tv[i].nw);
            for (int j = 0; j < tv[i].nw; j++) begin
                if (j < got_q.size()) begin
                    check($sformatf("v%0d_b%0d_data", i, j), got_q[j].data, tv[i].wd[j]);
                    check($sformatf("v%0d_b%0d_lanes", i, j), got_q[j].lanes, tv[i].wl[j]);
                    check($sformatf("v%0d_b%0d_last", i, j), got_q[j].last, tv[i].wlast[j]);
                    check($sformatf("v%0d_b%0d_sinfo", i, j), got_q[j].sinfo, tv[i].ws[j]);
                end
            end
            check($sformatf("v%0d_error", i), o_error, 0);
        end

        // ---------------- output back-pressure ----------------
        got_q.delete();
        i_wresp_accept = 1'b0;
        push_cmd(1'b0, 8'd4);
        send_beat(c_DA, 8'h20, 1'b0);
        check("stall_no_close_yet", o_wresp_valid, 0);
        send_beat(c_DB, 8'h21, 1'b0);
        check("stall_close_latency", o_wresp_valid, 1);
        check("stall_held_data", o_wdata, {c_DB, c_DA});
        send_beat(c_DC, 8'h22, 1'b0);   // lower lane, does not need the output register
        i_nresp_valid = 1'b1; i_ndata = c_DD; i_nsinfo = 8'h23; i_nresp_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_accept_low", o_nresp_accept, 0);
            @(negedge i_clk);
        end
        check("stall_data_kept", o_wdata, {c_DB, c_DA});
        i_wresp_accept = 1'b1;
        #1;
        check("stall_release_accept", o_nresp_accept, 1);
        @(negedge i_clk);
        i_nresp_valid = 1'b0; i_nresp_last = 1'b0;
        repeat (3) @(negedge i_clk);
        check("stall_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("stall_b0_data", got_q[0].data, {c_DB, c_DA});
            check("stall_b1_data", got_q[1].data, {c_DD, c_DC});
            check("stall_b1_last", got_q[1].last, 1);
            check("stall_b1_sinfo", got_q[1].sinfo, 8'h22);
        end

        // ---------------- info FIFO full ----------------
        // The idle packer pops the first command at once, so the four FIFO
        // entries are filled by the second through fifth pushes.
        got_q.delete();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fifo_ready_before_push", o_cmd_ready, 1);
            push_cmd(1'b0, 8'd2);
        end
        #1;
        check("fifo_full_ready_low", o_cmd_ready, 0);
        send_beat(64'h100, 8'h30, 1'b0);
        send_beat(64'h101, 8'h31, 1'b1);
        n = 0;
        #1;
        while (!o_cmd_ready && n < 4) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        check("fifo_ready_after_pop", o_cmd_ready, 1);
        @(negedge i_clk);
        for (int k = 1; k < 5; k++) begin
            send_beat(64'h100 + 64'(2*k), 8'h30, 1'b0);
            send_beat(64'h101 + 64'(2*k), 8'h31, 1'b1);
        end
        repeat (3) @(negedge i_clk);
        check("fifo_drain_count", got_q.size(), 5);
        if (got_q.size() == 5)
            check("fifo_last_data", got_q[4].data, {64'h109, 64'h108});

        // ---------------- early last -> sticky error ----------------
        got_q.delete();
        push_cmd(1'b0, 8'd4);
        send_beat(c_DA, 8'h40, 1'b0);
        send_beat(c_DB, 8'h41, 1'b1);
        check("err_set", o_error, 1);
        send_beat(c_DC, 8'h42, 1'b0);
        send_beat(c_DD, 8'h43, 1'b0);
        repeat (3) @(negedge i_clk);
        check("err_sticky", o_error, 1);
        check("err_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("err_b0_last", got_q[0].last, 0);
            check("err_b1_last", got_q[1].last, 1);
        end
        #1;
        check("err_back_idle", o_nresp_accept, 0);
        i_rst_n = 1'b0;
        #1;
        check("err_cleared_by_reset", o_error, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Missing last on the final beat also flags an error.
        got_q.delete();
        push_cmd(1'b0, 8'd1);
        send_beat(c_DA, 8'h50, 1'b0);
        repeat (2) @(negedge i_clk);
        check("err_missing_last", o_error, 1);
        check("err_missing_last_beat", got_q.size(), 1);

        // ---------------- reset mid-response ----------------
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        got_q.delete();
        push_cmd(1'b0, 8'd4);
        push_cmd(1'b1, 8'd2);
        send_beat(c_DA, 8'h60, 1'b0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        #1;
        check("rstmid_no_beats", got_q.size(), 0);
        check("rstmid_wresp_valid", o_wresp_valid, 0);
        check("rstmid_idle", o_nresp_accept, 0);
        check("rstmid_cmd_ready", o_cmd_ready, 1);
        @(negedge i_clk);
        push_cmd(1'b0, 8'd2);
        send_beat(c_DC, 8'h70, 1'b0);
        send_beat(c_DD, 8'h71, 1'b1);
        repeat (3) @(negedge i_clk);
        check("rstmid_fresh_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("rstmid_fresh_data", got_q[0].data, {c_DD, c_DC});
            check("rstmid_fresh_last", got_q[0].last, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
